// File: rtl/branch_resolver_if.sv
// Request/result bundle for branch_resolver.
// Optional BRANCH_UNSIGNED_EN adds the is_unsigned request bit.
interface branch_resolver_if #(
    parameter int PC_W = 12
);
    logic            start;
    logic            ready;
    logic [31:0]     operandA;
    logic [31:0]     operandB;
    logic [1:0]      op;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] offset;
`ifdef BRANCH_UNSIGNED_EN
    logic            is_unsigned;
`endif
    logic            done;
    logic            isEqual;
    logic            isLessThan;
    logic            isGreaterThan;
    logic            taken;
    logic [PC_W-1:0] next_pc;

`ifdef BRANCH_UNSIGNED_EN
    modport master (
        output start, operandA, operandB, op, pc, offset, is_unsigned,
        input  ready, done, isEqual, isLessThan, isGreaterThan,
        input  taken, next_pc
    );
    modport slave (
        input  start, operandA, operandB, op, pc, offset, is_unsigned,
        output ready, done, isEqual, isLessThan, isGreaterThan,
        output taken, next_pc
    );
`else
    modport master (
        output start, operandA, operandB, op, pc, offset,
        input  ready, done, isEqual, isLessThan, isGreaterThan,
        input  taken, next_pc
    );
    modport slave (
        input  start, operandA, operandB, op, pc, offset,
        output ready, done, isEqual, isLessThan, isGreaterThan,
        output taken, next_pc
    );
`endif
endinterface

// File: rtl/branch_resolver.sv
// Chunked-subtract compare-and-branch unit (IDLE -> RUN x N -> DONE).
// Define BRANCH_UNSIGNED_EN to enable the is_unsigned compare mode.
module branch_resolver #(
    parameter int CHUNK = 8,
    parameter int PC_W  = 12
) (
    input logic              clock,
    input logic              reset,
    branch_resolver_if.slave bus
);
    localparam int N = 32 / CHUNK;
    localparam logic [5:0] LAST = 6'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic            accept;
    logic            last;

    logic [31:0]     a_q, b_q;
    logic [1:0]      op_q;
    logic [PC_W-1:0] pc_q, off_q;
    logic            uns;
    logic            carry_q, zero_q;
    logic [5:0]      cnt_q;

    logic [CHUNK-1:0] a_c, nb_c, diff;
    logic [CHUNK:0]   sum;
    logic             cout, cin_msb, ovf;
    logic             eq_w, lt_w, gt_w, taken_w;
    logic [PC_W-1:0]  np_w;

    logic            eq_q, lt_q, gt_q, taken_q;
    logic [PC_W-1:0] np_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                accept   = bus.start;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign last = (cnt_q == LAST);

    // Operands shift right so the active chunk always sits at bit 0.
    assign a_c     = a_q[CHUNK-1:0];
    assign nb_c    = ~b_q[CHUNK-1:0];
    assign sum     = {1'b0, a_c} + {1'b0, nb_c} + {{CHUNK{1'b0}}, carry_q};
    assign diff    = sum[CHUNK-1:0];
    assign cout    = sum[CHUNK];
    assign cin_msb = a_c[CHUNK-1] ^ nb_c[CHUNK-1] ^ diff[CHUNK-1];
    assign ovf     = cin_msb ^ cout;

    assign eq_w = zero_q & (diff == '0);
    assign lt_w = uns ? ~cout : (diff[CHUNK-1] ^ ovf);
    assign gt_w = ~eq_w & ~lt_w;

    always_comb begin
        taken_w = 1'b0;
        unique case (op_q)
            2'b00: taken_w = eq_w;
            2'b01: taken_w = ~eq_w;
            2'b10: taken_w = lt_w;
            2'b11: taken_w = gt_w;
            default: taken_w = 1'b0;
        endcase
    end

    assign np_w = pc_q + PC_W'(1) + (taken_w ? off_q : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            pc_q    <= '0;
            off_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            taken_q <= 1'b0;
            np_q    <= '0;
        end else if (accept) begin
            a_q     <= bus.operandA;
            b_q     <= bus.operandB;
            op_q    <= bus.op;
            pc_q    <= bus.pc;
            off_q   <= bus.offset;
            carry_q <= 1'b1;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= cout;
            zero_q  <= eq_w;
            cnt_q   <= cnt_q + 6'd1;
            if (last) begin
                eq_q    <= eq_w;
                lt_q    <= lt_w;
                gt_q    <= gt_w;
                taken_q <= taken_w;
                np_q    <= np_w;
            end
        end
    end

`ifdef BRANCH_UNSIGNED_EN
    logic uns_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       uns_q <= 1'b0;
        else if (accept) uns_q <= bus.is_unsigned;
    end
    assign uns = uns_q;
`else
    assign uns = 1'b0;
`endif

    assign bus.ready         = (state != RUN);
    assign bus.done          = (state == DONE);
    assign bus.isEqual       = eq_q;
    assign bus.isLessThan    = lt_q;
    assign bus.isGreaterThan = gt_q;
    assign bus.taken         = taken_q;
    assign bus.next_pc       = np_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expectations queued on accept,
// popped and compared on every done pulse.
module tb_branch_resolver;
    localparam int CHUNK = 8;
    localparam int PC_W  = 12;
    localparam int N     = 32 / CHUNK;

    typedef struct packed {
        logic [2:0]      flags;
        logic            taken;
        logic [PC_W-1:0] npc;
        logic [31:0]     acc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] cyc;
    exp_t sb[$];
    exp_t mon_e;

    branch_resolver_if #(.PC_W(PC_W)) bus ();

    branch_resolver #(.CHUNK(CHUNK), .PC_W(PC_W)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [PC_W-1:0] pc,
                                   input logic [PC_W-1:0] off,
                                   input logic uns, input logic [31:0] acc);
        exp_t e;
        logic eq, lt, gt, tk;
        eq = (a == b);
        lt = uns ? (a < b) : ($signed(a) < $signed(b));
        gt = !eq && !lt;
        case (op)
            2'b00:   tk = eq;
            2'b01:   tk = !eq;
            2'b10:   tk = lt;
            default: tk = gt;
        endcase
        e.flags = {eq, lt, gt};
        e.taken = tk;
        e.npc   = tk ? pc + PC_W'(1) + off : pc + PC_W'(1);
        e.acc   = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("flags", 32'({bus.isEqual, bus.isLessThan,
                                    bus.isGreaterThan}), 32'(mon_e.flags));
                check("taken", 32'(bus.taken), 32'(mon_e.taken));
                check("next_pc", 32'(bus.next_pc), 32'(mon_e.npc));
                check("latency", cyc - mon_e.acc, 32'(N));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [PC_W-1:0] pc,
                        input logic [PC_W-1:0] off, input logic uns);
        int k = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && k < 100) begin
            bus.start = 1'b0;
            k++;
            @(negedge clk);
        end
        if (k >= 100) check("ready_timeout", 32'd0, 32'd1);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.operandA = a;
        bus.operandB = b;
        bus.pc       = pc;
        bus.offset   = off;
`ifdef BRANCH_UNSIGNED_EN
        bus.is_unsigned = uns;
`endif
        @(posedge clk);
        #1;
        sb.push_back(model(op, a, b, pc, off, uns, cyc));
    endtask

    task automatic drain();
        int k = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.operandA = '0;
        bus.operandB = '0;
        bus.pc       = '0;
        bus.offset   = '0;
`ifdef BRANCH_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_flags", 32'({bus.isEqual, bus.isLessThan,
                                bus.isGreaterThan}), 32'd0);
        check("rst_taken", 32'(bus.taken), 32'd0);
        check("rst_next_pc", 32'(bus.next_pc), 32'd0);

        send(2'b00, 32'd5, 32'd5, 12'd100, 12'd20, 1'b0);
        @(negedge clk);
        bus.operandA = 32'd9;
        check("run_ready", 32'(bus.ready), 32'd0);
        drain();

        send(2'b10, 32'hFFFF_FFFF, 32'd1, 12'd10, 12'hFFC, 1'b0);
        drain();
        send(2'b11, 32'hFFFF_FFFF, 32'd1, 12'd10, 12'hFFC, 1'b0);
        drain();

        send(2'b10, 32'h8000_0000, 32'd1, 12'd0, 12'd8, 1'b0);
        drain();
        send(2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 12'd40, 12'd3, 1'b0);
        drain();
        send(2'b10, 32'd1, 32'hFFFF_FFFF, 12'd50, 12'd2, 1'b0);
        drain();
`ifdef BRANCH_UNSIGNED_EN
        send(2'b10, 32'd1, 32'hFFFF_FFFF, 12'd50, 12'd2, 1'b1);
        drain();
        send(2'b11, 32'h8000_0000, 32'd1, 12'd60, 12'd4, 1'b1);
        drain();
`endif

        send(2'b01, 32'd7, 32'd7, 12'hFFF, 12'd0, 1'b0);
        drain();
        send(2'b00, 32'h1234, 32'h1234, 12'hFFE, 12'd1, 1'b0);
        drain();

        // A request presented mid-run must be dropped.
        send(2'b00, 32'd3, 32'd4, 12'd200, 12'd5, 1'b0);
        @(negedge clk);
        bus.operandA = 32'd6;
        bus.operandB = 32'd6;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        drain();

        send(2'b01, 32'hDEAD_BEEF, 32'h0000_0001, 12'd300, 12'h010, 1'b0);
        send(2'b11, 32'd2, 32'd9, 12'd400, 12'h020, 1'b0);
        send(2'b10, 32'hFFFF_FF00, 32'hFFFF_FF01, 12'd500, 12'hF00, 1'b0);
        drain();

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? ra : $urandom;
            send(2'($urandom_range(0, 3)), ra, rb,
                 12'($urandom), 12'($urandom), 1'b0);
        end
        drain();

        send(2'b00, 32'd8, 32'd8, 12'd77, 12'd1, 1'b0);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_flags", 32'({bus.isEqual, bus.isLessThan,
                                  bus.isGreaterThan}), 32'd0);
        check("abort_taken", 32'(bus.taken), 32'd0);
        check("abort_next_pc", 32'(bus.next_pc), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_abort_next_pc", 32'(bus.next_pc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Multi-cycle compare-and-branch unit on the consumer side of the processor's compare path.
- Accepts two 32-bit register operands plus a branch opcode, PC and offset.
- Resolves the compare by bit-serial (chunked) subtraction over several cycles, then returns the flags, a taken decision and the next PC.
- Sits between decode/register-read and the fetch PC mux; area-reduced alternative to a full 32-bit lookahead subtractor.

Parameters:
- CHUNK, 8: bits subtracted per cycle; must be one of 1, 2, 4, 8, 16 or 32.
- PC_W, 12: width of pc, offset and next_pc.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only while ready=1.
- ready  out  1  high when a new request can be accepted.
- operandA  in  32  first operand; latched on an accepted start.
- operandB  in  32  second operand; latched on an accepted start.
- op  in  2  branch type: 00 BEQ, 01 BNE, 10 BLT, 11 BGT.
- pc  in  PC_W  address of the branch instruction; latched on start.
- offset  in  PC_W  branch displacement, two's complement; latched on start.
- done  out  1  one-cycle pulse when results are valid.
- isEqual  out  1  A==B, held until the next done.
- isLessThan  out  1  A<B, held until the next done.
- isGreaterThan  out  1  A>B, held until the next done.
- taken  out  1  branch decision, held until the next done.
- next_pc  out  PC_W  pc+1+offset if taken, else pc+1; held until the next done.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - ready=1; done=0; all flags 0; taken=0; next_pc=0.
  - Internal operand, carry, zero-accumulator and chunk-counter registers cleared.
- States: IDLE, RUN, DONE. N = 32/CHUNK.
- IDLE:
  - ready=1.
  - start=1 latches operandA, operandB, op, pc and offset.
  - Sets carry=1 and zero_acc=1, clears the counter, then moves to RUN.
- RUN:
  - ready=0.
  - Each edge computes chunk k of A + ~B + carry, using bits [k*CHUNK +: CHUNK].
  - Stores the carry-out and ANDs zero_acc with (chunk diff == 0).
  - On the last chunk, also captures the diff sign bit and the overflow bit (carry into bit 31 XOR carry out of bit 31).
  - After N edges moves to DONE; start is ignored throughout RUN.
- DONE (exactly one cycle):
  - done=1.
  - Result registers are loaded on the edge entering DONE and are visible during DONE.
  - ready=1; start here is accepted (back-to-back) and goes to RUN, otherwise the block returns to IDLE.
- Latency: done is high in the cycle following the N-th edge after the accepting edge. With CHUNK=8 that is N=4 RUN edges, so done is visible 5 cycles after start is presented.
- Flags:
  - isEqual = zero_acc.
  - isLessThan = sign XOR overflow, a correct signed compare including overflow.
  - isGreaterThan = ~isEqual & ~isLessThan.
  - Exactly one flag is high after the first done.
- taken:
  - BEQ: isEqual.
  - BNE: ~isEqual.
  - BLT: isLessThan.
  - BGT: isGreaterThan.
- next_pc arithmetic is modulo 2^PC_W: wraps silently, with no overflow flag.
- Input operands may change freely after the accepting edge without affecting the result.
- Reset asserted mid-RUN aborts the operation: no done is produced, and the outputs read 0 from the reset assertion onward.

Optional Feature:
- BRANCH_UNSIGNED_EN defined:
  - Adds input port is_unsigned (1 bit), latched with the other operands on start.
  - When is_unsigned=1, isLessThan = ~final carry-out (borrow); the overflow term is unused.
- Undefined: the port is absent and comparisons are always signed.

Test Plan:
- Reset, then idle 3 cycles -> ready=1, done=0, flags=000, taken=0, next_pc=0.
- CHUNK=8, BEQ A=5 B=5 pc=100 offset=20 -> done after 4 RUN edges, isEqual=1, taken=1, next_pc=121; ready=0 during RUN.
- BLT A=0xFFFFFFFF B=1 pc=10 offset=-4 -> isLessThan=1, taken=1, next_pc=7. Then BGT with the same operands -> taken=0, next_pc=11.
- Overflow:
  - BLT A=0x80000000 B=1 -> isLessThan=1.
  - BGT A=0x7FFFFFFF B=0xFFFFFFFF -> isGreaterThan=1, taken=1.
  - With BRANCH_UNSIGNED_EN and is_unsigned=1: A=1 B=0xFFFFFFFF BLT -> isLessThan=1.
- Request handling:
  - start pulsed again in RUN with different operands -> ignored; the result matches the first request.
  - start held high in the DONE cycle -> a second op accepted with no IDLE gap.
  - reset pulsed at RUN edge 2 -> no done pulse; all outputs 0.
- Wrap-around, PC_W=12:
  - pc=0xFFF offset=0 BNE A=B -> taken=0, next_pc=0x000.
  - pc=0xFFE offset=1 BEQ A=B -> next_pc=0x000.
